red_pitaya_daisy_tx_frm: RTL and testbench

Framing stage directly upstream of the daisy-chain TX serializer, in the parallel clock domain. Buffers 16-bit user words in a small FIFO and issues them to the serializer's parallel port under its ready handshake. Inserts a training pattern on request and a sync word every FRM_LEN data words so the far-end receiver can align.

---
 rtl/red_pitaya_daisy_pkg.sv | 23 ++
 rtl/red_pitaya_daisy_fifo.sv | 57 +++++
 rtl/red_pitaya_daisy_tx_frm.sv | 156 +++++++++++++++
 tb/tb_red_pitaya_daisy_tx_frm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_daisy_pkg.sv
// Shared types and constants for the daisy-chain TX framer.
package red_pitaya_daisy_pkg;

  typedef enum logic [1:0] {
    StDis   = 2'd0,
    StTrain = 2'd1,
    StSync  = 2'd2,
    StData  = 2'd3
  } frm_state_e;

  // Origin of the word held in the output register, used for statistics.
  typedef enum logic [1:0] {
    KindNone  = 2'd0,
    KindTrain = 2'd1,
    KindSync  = 2'd2,
    KindData  = 2'd3
  } word_kind_e;

  localparam logic [15:0] TRAIN_WORD_DEF = 16'h00FF;
  localparam logic [15:0] SYNC_WORD_DEF  = 16'hA55A;
  localparam int unsigned FRM_CNT_W      = 16;

endpackage

// File: rtl/red_pitaya_daisy_fifo.sv
// Show-ahead FIFO with synchronous flush; head word is visible on rdat while non-empty.
module red_pitaya_daisy_fifo #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] wdat,
  input  logic          rd,
  output logic [DW-1:0] rdat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   cnt
);

  localparam int unsigned  Depth  = 2 ** AW;
  localparam logic [AW:0]  DepthC = (AW + 1)'(Depth);

  logic [DW-1:0] mem [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_wr, do_rd;

  assign full  = (cnt_q == DepthC);
  assign empty = (cnt_q == '0);
  assign do_wr = wr && !full && !flush;
  assign do_rd = rd && !empty && !flush;
  assign rdat  = mem[rptr_q];
  assign cnt   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/red_pitaya_daisy_tx_frm.sv
// Daisy-chain TX framer: buffers user words and emits training, sync and data words
// toward the serializer under its ready handshake.
module red_pitaya_daisy_tx_frm
  import red_pitaya_daisy_pkg::*;
#(
  parameter int unsigned FIFO_AW    = 3,
  parameter int unsigned FRM_LEN    = 256,
  parameter logic [15:0] TRAIN_WORD = TRAIN_WORD_DEF,
  parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEF
) (
  input  logic        par_clk_i,
  input  logic        par_rstn_i,
  input  logic        cfg_en_i,
  input  logic        cfg_train_i,
  input  logic        usr_dv_i,
  input  logic [15:0] usr_dat_i,
  output logic        usr_rdy_o,
  input  logic        par_rdy_i,
  output logic        par_dv_o,
  output logic [15:0] par_dat_o,
  output logic [31:0] stat_words_o,
  output logic [15:0] stat_frames_o
);

  localparam logic [FRM_CNT_W-1:0] FrmLen = FRM_LEN[FRM_CNT_W-1:0];

  frm_state_e             state_q, state_d;
  word_kind_e             kind_q, kind_d;
  logic                   dv_q, dv_d;
  logic [15:0]            dat_q, dat_d;
  logic [FRM_CNT_W-1:0]   frm_cnt_q, frm_cnt_d, frm_cnt_inc;
  logic [31:0]            words_q;
  logic [15:0]            frames_q;

  logic                   fifo_wr, fifo_rd, fifo_flush, fifo_full, fifo_empty;
  logic [15:0]            fifo_rdat;
  logic [FIFO_AW:0]       fifo_cnt_unused;
  logic                   load, accept;

  assign load        = !dv_q || par_rdy_i;
  assign accept      = dv_q && par_rdy_i;
  assign frm_cnt_inc = frm_cnt_q + 1'b1;

  // Writes are refused while disabled because the FIFO is held flushed there.
  assign usr_rdy_o = cfg_en_i && !fifo_full && (state_q != StDis);
  assign fifo_wr   = usr_dv_i && usr_rdy_o;

  red_pitaya_daisy_fifo #(
    .AW (FIFO_AW),
    .DW (16)
  ) u_fifo (
    .clk   (par_clk_i),
    .rst_n (par_rstn_i),
    .flush (fifo_flush),
    .wr    (fifo_wr),
    .wdat  (usr_dat_i),
    .rd    (fifo_rd),
    .rdat  (fifo_rdat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt_unused)
  );

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    dv_d       = dv_q;
    dat_d      = dat_q;
    frm_cnt_d  = frm_cnt_q;
    fifo_rd    = 1'b0;
    fifo_flush = 1'b0;

    // A taken word empties the register unless the state below refills it.
    if (accept) begin
      dv_d   = 1'b0;
      dat_d  = '0;
      kind_d = KindNone;
    end

    if (!cfg_en_i) begin
      state_d    = StDis;
      dv_d       = 1'b0;
      dat_d      = '0;
      kind_d     = KindNone;
      fifo_flush = 1'b1;
    end else begin
      unique case (state_q)
        StDis: begin
          fifo_flush = 1'b1;
          state_d    = cfg_train_i ? StTrain : StSync;
        end
        StTrain: begin
          if (load) begin
            if (cfg_train_i) begin
              dv_d   = 1'b1;
              dat_d  = TRAIN_WORD;
              kind_d = KindTrain;
            end else begin
              state_d = StSync;
            end
          end
        end
        StSync: begin
          if (load) begin
            dv_d      = 1'b1;
            dat_d     = SYNC_WORD;
            kind_d    = KindSync;
            frm_cnt_d = '0;
            state_d   = StData;
          end
        end
        StData: begin
          if (load) begin
            if (cfg_train_i) begin
              state_d = StTrain;
            end else if (!fifo_empty) begin
              fifo_rd   = 1'b1;
              dv_d      = 1'b1;
              dat_d     = fifo_rdat;
              kind_d    = KindData;
              frm_cnt_d = frm_cnt_inc;
              if (frm_cnt_inc == FrmLen) state_d = StSync;
            end
          end
        end
        default: state_d = StDis;
      endcase
    end
  end

  always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
    if (!par_rstn_i) begin
      state_q   <= StDis;
      kind_q    <= KindNone;
      dv_q      <= 1'b0;
      dat_q     <= '0;
      frm_cnt_q <= '0;
      words_q   <= '0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      dv_q      <= dv_d;
      dat_q     <= dat_d;
      frm_cnt_q <= frm_cnt_d;
      if (accept && kind_q == KindData) words_q  <= words_q + 1'b1;
      if (accept && kind_q == KindSync) frames_q <= frames_q + 1'b1;
    end
  end

  assign par_dv_o      = dv_q;
  assign par_dat_o     = dat_q;
  assign stat_words_o  = words_q;
  assign stat_frames_o = frames_q;

endmodule

// File: tb/tb_red_pitaya_daisy_tx_frm.sv
// Directed bench for the daisy TX framer with FRM_LEN=4 and an 8-deep FIFO.
module tb_red_pitaya_daisy_tx_frm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_en = 1'b0, cfg_train = 1'b0;
  logic        usr_dv = 1'b0;
  logic [15:0] usr_dat = '0;
  logic        usr_rdy;
  logic        par_rdy = 1'b0;
  logic        par_dv;
  logic [15:0] par_dat;
  logic [31:0] stat_words;
  logic [15:0] stat_frames;

  logic        rdy_en = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] acc_q[$];
  logic [15:0] exp_seq[12];
  logic [15:0] held;
  int          base;

  red_pitaya_daisy_tx_frm #(
    .FIFO_AW    (3),
    .FRM_LEN    (4),
    .TRAIN_WORD (16'h00FF),
    .SYNC_WORD  (16'hA55A)
  ) u_dut (
    .par_clk_i     (clk),
    .par_rstn_i    (rst_n),
    .cfg_en_i      (cfg_en),
    .cfg_train_i   (cfg_train),
    .usr_dv_i      (usr_dv),
    .usr_dat_i     (usr_dat),
    .usr_rdy_o     (usr_rdy),
    .par_rdy_i     (par_rdy),
    .par_dv_o      (par_dv),
    .par_dat_o     (par_dat),
    .stat_words_o  (stat_words),
    .stat_frames_o (stat_frames)
  );

  always #5 clk = ~clk;

  // Serializer model: ready one cycle in four while enabled.
  always @(negedge clk) begin
    cyc     <= cyc + 1;
    par_rdy <= rdy_en && (cyc[1:0] == 2'd0);
  end

  always @(posedge clk) begin
    if (par_dv && par_rdy) acc_q.push_back(par_dat);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_acc(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (acc_q.size() >= n) break;
    end
    check("acc_count", acc_q.size(), n);
  endtask

  initial begin
    exp_seq = '{16'hA55A, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hA55A,
                16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'hA55A, 16'h0009};

    repeat (3) @(negedge clk);
    check("rst_dv", par_dv, 1'b0);
    check("rst_dat", par_dat, 16'h0);
    check("rst_usr_rdy", usr_rdy, 1'b0);
    check("rst_words", stat_words, 32'd0);
    check("rst_frames", stat_frames, 16'd0);

    // Get a training word pending, then reset asynchronously mid-cycle.
    rst_n = 1'b1;
    cfg_en = 1'b1;
    cfg_train = 1'b1;
    repeat (3) @(negedge clk);
    check("pend_dv", par_dv, 1'b1);
    check("pend_dat", par_dat, 16'h00FF);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dv", par_dv, 1'b0);
    check("arst_dat", par_dat, 16'h0);
    check("arst_usr_rdy", usr_rdy, 1'b0);
    check("arst_state", u_dut.state_q, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Training, then switch to framing; one already-loaded training word drains first.
    rdy_en = 1'b1;
    wait_acc(5, 100);
    cfg_train = 1'b0;
    check("train_words", stat_words, 32'd0);
    wait_acc(6, 100);
    rdy_en = 1'b0;
    for (int i = 0; i < 6; i++) check($sformatf("train_%0d", i), acc_q[i], 16'h00FF);

    // Fill the FIFO while the sync word is held.
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("fill_rdy_%0d", i), usr_rdy, 1'b1);
      usr_dv = 1'b1;
      usr_dat = 16'(i);
    end
    @(negedge clk);
    usr_dat = 16'h0009;
    check("full_rdy", usr_rdy, 1'b0);
    check("held_sync_dv", par_dv, 1'b1);
    check("held_sync_dat", par_dat, 16'hA55A);
    rdy_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (usr_rdy) begin
        @(negedge clk);
        break;
      end
    end
    usr_dv = 1'b0;
    wait_acc(18, 300);
    for (int i = 0; i < 12; i++) check($sformatf("seq_%0d", i), acc_q[6 + i], exp_seq[i]);
    check("words_9", stat_words, 32'd9);
    check("frames_3", stat_frames, 16'd3);

    // Empty FIFO in DATA, then a single write.
    rdy_en = 1'b0;
    check("empty_dv", par_dv, 1'b0);
    check("empty_dat", par_dat, 16'h0);
    usr_dv = 1'b1;
    usr_dat = 16'h1234;
    @(negedge clk);
    usr_dv = 1'b0;
    check("lat1_dv", par_dv, 1'b0);
    @(negedge clk);
    check("lat2_dv", par_dv, 1'b1);
    check("lat2_dat", par_dat, 16'h1234);

    // Stall: output held without ready.
    held = par_dat;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("stall_dat_%0d", i), par_dat, 16'h1234);
      check($sformatf("stall_dv_%0d", i), par_dv, 1'b1);
    end
    check("stall_no_acc", acc_q.size(), 18);

    // Disable with three words buffered and one pending.
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      usr_dv = 1'b1;
      usr_dat = 16'h0B00 + 16'(i);
    end
    @(negedge clk);
    usr_dv = 1'b0;
    check("dis_fifo_cnt", u_dut.u_fifo.cnt, 4'd3);
    check("dis_pend_dat", par_dat, held);
    cfg_en = 1'b0;
    @(negedge clk);
    check("dis_dv", par_dv, 1'b0);
    check("dis_dat", par_dat, 16'h0);
    check("dis_fifo_flushed", u_dut.u_fifo.cnt, 4'd0);
    check("dis_usr_rdy", usr_rdy, 1'b0);

    cfg_en = 1'b1;
    rdy_en = 1'b1;
    base = acc_q.size();
    wait_acc(base + 1, 100);
    check("reen_sync", acc_q[base], 16'hA55A);
    repeat (30) @(negedge clk);
    check("reen_no_old", acc_q.size(), base + 1);
    check("final_words", stat_words, 32'd9);
    check("final_frames", stat_frames, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
